sc_io_stimulus: RTL and testbench
=================================

SC_IO_STIMULUS -- requirements
Module: sc_io_stimulus

Interface
REQ-001 Parameter WIDTH, default 32, bit width of each I/O port channel.
REQ-002 Parameter NCH, default 2, number of input/output port channel pairs.
REQ-003 Parameter RST_CYCLES, default 5, number of cycles dut_resetn is held low after a run starts; legal range 1..255.
REQ-004 Parameter HOLD_CYCLES, default 4, number of cycles each stimulus value is held; legal range 1..65535.
REQ-005 Parameter TIMEOUT_CYCLES, default 31250, number of RUN cycles before capture; legal range 1..2^24-1.
REQ-006 Parameter LFSR_TAPS, default 32'h80200003, Galois feedback mask, low WIDTH bits used.
REQ-007 clock  in  1  single system clock; all logic is on its rising edge.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 restart  in  1  single-cycle request to begin a new run; acted on only in DONE.
REQ-010 mode  in  2*NCH  per-channel stimulus mode, channel k at bits [2k+1:2k]: 0 zero, 1 constant, 2 ramp, 3 LFSR.
REQ-011 seed  in  WIDTH*NCH  per-channel seed, channel k at bits [WIDTH*k+WIDTH-1:WIDTH*k].
REQ-012 out_port  in  WIDTH*NCH  DUT output ports, same packing as seed.
REQ-013 dut_resetn  out  1  active-low reset driven to the DUT.
REQ-014 in_port  out  WIDTH*NCH  stimulus driven to the DUT input ports, same packing as seed.
REQ-015 cap_data  out  WIDTH*NCH  out_port value latched at timeout.
REQ-016 cap_valid  out  1  one-cycle pulse marking the cycle cap_data is updated.
REQ-017 done  out  1  high while in DONE.

Function
REQ-018 FSM states RST_HOLD, RUN, CAPTURE, DONE; no other encodings are reachable.
- RST_HOLD: dut_resetn=0, in_port=0; counts RST_CYCLES cycles, then goes to RUN.
- Entry to RUN: mode and seed are latched; later changes have no effect until the next run.
- Entry to RUN: each channel loads its initial value: 0 in mode 0, seed in modes 1/2, seed in mode 3 unless seed is zero, in which case all ones.
REQ-019 RUN: dut_resetn=1; the hold counter advances every cycle; on reaching HOLD_CYCLES-1 it clears and every channel steps once.
- Mode 0/1: value unchanged.
- Mode 2: value+1 modulo 2^WIDTH; all ones wraps to 0.
- Mode 3: Galois shift right; when the old bit0 is 1, XOR with the LFSR_TAPS mask.
REQ-020 RUN timer counts RUN cycles; in the cycle the count equals TIMEOUT_CYCLES-1, the next state is CAPTURE.
REQ-021 CAPTURE, lasting exactly one cycle: cap_data <= out_port and cap_valid=1; the next state is DONE; in_port is frozen.
REQ-022 DONE: done=1, dut_resetn=1, in_port and cap_data hold; restart=1 moves to RST_HOLD and clears the timer, hold counter and done.
REQ-023 restart is ignored in RST_HOLD, RUN and CAPTURE.
REQ-024 Asserting reset in any state, including mid-RUN or CAPTURE, forces the reset values on the next edge; reset wins over a simultaneous restart.
REQ-025 Every output is registered; no combinational path exists from any input to any output.

Reset
REQ-026 On reset=1 at a rising edge, the following apply: state=RST_HOLD, dut_resetn=0, in_port=0, cap_data=0, cap_valid=0, done=0, all counters=0.
REQ-027 After reset deasserts, the block begins a run without needing restart.

Structure
REQ-028 Package sc_io_pkg holds the FSM state enum, mode encodings and the default LFSR_TAPS constant.
REQ-029 Sub-module sc_io_chan (one instance per channel, generated NCH times) holds the channel value register and the mode step logic.
- Inputs of sc_io_chan: load, step, mode, seed.
- The FSM and counters stay in the top level.

Verification
REQ-030 Bench parameters: WIDTH=8, NCH=2, RST_CYCLES=5, HOLD_CYCLES=2, TIMEOUT_CYCLES=20; bench clock period 4 ps.
REQ-031 Reset, then release: dut_resetn=0 for exactly 5 cycles after reset falls, then 1; in_port=0 throughout.
REQ-032 Mode 2 on ch0, seed 8'hFE:
- in_port[7:0] sequence FE,FE,FF,FF,00,00,01 in successive RUN cycles.
- cap_valid pulses once after 20 RUN cycles; done=1 on the following cycle.
REQ-033 Mode 3 on ch1 with seed 0: the first RUN value is 8'hFF, and each step matches a Galois reference model using taps 8'h03.
REQ-034 Capture timing: out_port=16'hA55A held constant → cap_data=16'hA55A with a single cap_valid pulse; cap_data holds in DONE; restart then reruns RST_HOLD for 5 cycles.
REQ-035 Reset mid-RUN (cycle 10) asserted together with restart → reset values on the next edge; the block then reruns RST_HOLD for 5 cycles.
- No cap_valid pulse occurs in the aborted run.

Source files
------------

// File: rtl/sc_io_pkg.sv
// Shared types for the I/O stimulus generator: FSM states, channel modes
// and the default Galois LFSR feedback mask.
package sc_io_pkg;

    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'd0,
        ST_RUN      = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_ZERO  = 2'd0,
        MODE_CONST = 2'd1,
        MODE_RAMP  = 2'd2,
        MODE_LFSR  = 2'd3
    } mode_t;

    localparam logic [31:0] DEFAULT_LFSR_TAPS = 32'h8020_0003;

endpackage

// File: rtl/sc_io_chan.sv
// One stimulus channel: latches its mode on load and steps its value
// (hold, ramp or Galois LFSR) whenever the top level asks it to.
module sc_io_chan
    import sc_io_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_LFSR_TAPS)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] value
);

    mode_t            mode_q;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] step_value;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        load_value = '0;
        case (mode_t'(mode))
            MODE_CONST, MODE_RAMP: load_value = seed;
            // An all-zero LFSR would lock up, so a zero seed starts from all ones.
            MODE_LFSR:             load_value = (seed == '0) ? '1 : seed;
            default:               load_value = '0;
        endcase
    end

    always_comb begin
        step_value = value;
        case (mode_q)
            MODE_RAMP: step_value = value + WIDTH'(1);
            MODE_LFSR: step_value = (value >> 1) ^ (value[0] ? TAPS : '0);
            default:   step_value = value;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (clear) begin
            value  <= '0;
            mode_q <= MODE_ZERO;
        end else if (load) begin
            value  <= load_value;
            mode_q <= mode_t'(mode);
        end else if (step) begin
            value  <= step_value;
        end
    end

endmodule

// File: rtl/sc_io_stimulus.sv
// Stimulus generator for a DUT: holds it in reset, drives per-channel
// patterns for a fixed run, then captures the DUT outputs once.
module sc_io_stimulus
    import sc_io_pkg::*;
#(
    parameter int          WIDTH          = 32,
    parameter int          NCH            = 2,
    parameter int          RST_CYCLES     = 5,
    parameter int          HOLD_CYCLES    = 4,
    parameter int          TIMEOUT_CYCLES = 31250,
    parameter logic [31:0] LFSR_TAPS      = DEFAULT_LFSR_TAPS
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 restart,
    input  logic [2*NCH-1:0]     mode,
    input  logic [WIDTH*NCH-1:0] seed,
    input  logic [WIDTH*NCH-1:0] out_port,
    output logic                 dut_resetn,
    output logic [WIDTH*NCH-1:0] in_port,
    output logic [WIDTH*NCH-1:0] cap_data,
    output logic                 cap_valid,
    output logic                 done
);

    localparam logic [7:0]       RST_LAST   = 8'(RST_CYCLES - 1);
    localparam logic [15:0]      HOLD_LAST  = 16'(HOLD_CYCLES - 1);
    localparam logic [23:0]      TIMER_LAST = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [WIDTH-1:0] TAPS       = WIDTH'(LFSR_TAPS);

    state_t      state;
    state_t      state_next;
    logic [7:0]  rst_cnt;
    logic [15:0] hold_cnt;
    logic [23:0] timer;
    logic        restart_go;
    logic        chan_clear;
    logic        chan_load;
    logic        chan_step;

    assign restart_go = (state == ST_DONE) && restart;
    assign chan_clear = reset || restart_go;
    assign chan_load  = (state == ST_RST_HOLD) && (rst_cnt == RST_LAST);
    assign chan_step  = (state == ST_RUN) && (hold_cnt == HOLD_LAST);

    always_comb begin
        state_next = state;
        case (state)
            ST_RST_HOLD: if (rst_cnt == RST_LAST) state_next = ST_RUN;
            ST_RUN:      if (timer == TIMER_LAST) state_next = ST_CAPTURE;
            ST_CAPTURE:  state_next = ST_DONE;
            ST_DONE:     if (restart) state_next = ST_RST_HOLD;
            default:     state_next = ST_RST_HOLD;
        endcase
    end

    // Outputs are decoded from the next state so they stay registered yet line up with the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_RST_HOLD;
            rst_cnt    <= '0;
            hold_cnt   <= '0;
            timer      <= '0;
            dut_resetn <= 1'b0;
            cap_data   <= '0;
            cap_valid  <= 1'b0;
            done       <= 1'b0;
        end else begin
            state   <= state_next;
            rst_cnt <= (state == ST_RST_HOLD && state_next == ST_RST_HOLD) ? rst_cnt + 8'd1 : '0;
            if (restart_go) begin
                hold_cnt <= '0;
                timer    <= '0;
            end else if (state == ST_RUN) begin
                hold_cnt <= chan_step ? '0 : hold_cnt + 16'd1;
                timer    <= timer + 24'd1;
            end
            dut_resetn <= (state_next != ST_RST_HOLD);
            cap_valid  <= (state_next == ST_CAPTURE);
            done       <= (state_next == ST_DONE);
            if (state_next == ST_CAPTURE) cap_data <= out_port;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        sc_io_chan #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS)
        ) u_chan (
            .clock (clock),
            .clear (chan_clear),
            .load  (chan_load),
            .step  (chan_step),
            .mode  (mode[2*k +: 2]),
            .seed  (seed[WIDTH*k +: WIDTH]),
            .value (in_port[WIDTH*k +: WIDTH])
        );
    end

endmodule

// File: tb/tb_sc_io_stimulus.sv
// Randomized bench for sc_io_stimulus: a cycle-indexed reference model of one
// run (reset hold, stepped patterns, capture, done) checked every cycle.
`timescale 1ps/1ps
module tb_sc_io_stimulus;

    localparam int         W     = 8;
    localparam int         RSTC  = 5;
    localparam int         HOLDC = 2;
    localparam int         TOC   = 20;
    localparam logic [7:0] TAPS8 = 8'h03;
    localparam int         LAST  = RSTC + TOC + 2;   // a couple of DONE cycles

    logic        clock;
    logic        reset;
    logic        restart;
    logic [3:0]  mode;
    logic [15:0] seed;
    logic [15:0] out_port;
    logic        dut_resetn;
    logic [15:0] in_port;
    logic [15:0] cap_data;
    logic        cap_valid;
    logic        done;

    int          n_tests;
    int          n_fail;
    logic [15:0] exp_cap;

    sc_io_stimulus #(
        .WIDTH          (W),
        .NCH            (2),
        .RST_CYCLES     (RSTC),
        .HOLD_CYCLES    (HOLDC),
        .TIMEOUT_CYCLES (TOC)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .restart    (restart),
        .mode       (mode),
        .seed       (seed),
        .out_port   (out_port),
        .dut_resetn (dut_resetn),
        .in_port    (in_port),
        .cap_data   (cap_data),
        .cap_valid  (cap_valid),
        .done       (done)
    );

    initial clock = 1'b0;
    always #2 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_init(input logic [1:0] m, input logic [7:0] s);
        case (m)
            2'd1, 2'd2: return s;
            2'd3:       return (s == 8'h00) ? 8'hFF : s;
            default:    return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] m_after(input logic [1:0] m, input logic [7:0] s, input int n);
        logic [7:0] v;
        v = m_init(m, s);
        for (int i = 0; i < n; i++) begin
            if (m == 2'd2) v = v + 8'd1;
            else if (m == 2'd3) v = (v >> 1) ^ (v[0] ? TAPS8 : 8'h00);
        end
        return v;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, " rstn"}, 16'(dut_resetn), 16'h0);
        check({tag, " in"},   in_port,         16'h0);
        check({tag, " cap"},  cap_data,        16'h0);
        check({tag, " cv"},   16'(cap_valid),  16'h0);
        check({tag, " done"}, 16'(done),       16'h0);
    endtask

    // Called at the negedge of cycle 0 of a run (first cycle after the edge that
    // reset/restarted the block). Returns at a negedge: after LAST cycles in DONE,
    // or, when abort_at >= 0, just after a reset+restart applied at that cycle.
    task automatic run_check(input logic [3:0] rmode, input logic [15:0] rseed,
                             input int abort_at, input bit fixed_out,
                             input logic [15:0] fixed_val, input bit directed);
        logic [7:0]  ramp_tbl [7];
        logic [15:0] cap_src;
        logic [15:0] exp_in;
        int          n;
        ramp_tbl = '{8'hFE, 8'hFE, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h01};
        cap_src  = '0;
        for (int c = 0; c <= LAST; c++) begin
            if (c < RSTC) exp_in = '0;
            else begin
                n = ((c - RSTC) < TOC ? (c - RSTC) : TOC) / HOLDC;
                exp_in = {m_after(rmode[3:2], rseed[15:8], n), m_after(rmode[1:0], rseed[7:0], n)};
            end
            if (c == RSTC + TOC) exp_cap = cap_src;
            check($sformatf("c%0d rstn", c), 16'(dut_resetn), 16'(c >= RSTC));
            check($sformatf("c%0d in",   c), in_port,         exp_in);
            check($sformatf("c%0d cv",   c), 16'(cap_valid),  16'(c == RSTC + TOC));
            check($sformatf("c%0d done", c), 16'(done),       16'(c > RSTC + TOC));
            check($sformatf("c%0d cap",  c), cap_data,        exp_cap);
            if (directed && c >= RSTC && c < RSTC + 7)
                check($sformatf("ramp r%0d", c - RSTC), {8'h00, in_port[7:0]}, {8'h00, ramp_tbl[c - RSTC]});
            if (directed && c == RSTC)
                check("lfsr zero seed", {8'h00, in_port[15:8]}, 16'h00FF);
            if (c == abort_at) begin
                reset   = 1'b1;
                restart = 1'b1;
                @(negedge clock);
                exp_cap = '0;
                check_reset_values("abort");
                reset   = 1'b0;
                restart = 1'b0;
                return;
            end
            if (c == RSTC - 1) begin
                mode = rmode;
                seed = rseed;
            end else begin
                mode = 4'($urandom);
                seed = 16'($urandom);
            end
            out_port = fixed_out ? fixed_val : 16'($urandom);
            if (c == RSTC + TOC - 1) cap_src = out_port;
            restart = (c <= RSTC + TOC) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (c < LAST) @(negedge clock);
        end
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
    endtask

    function automatic logic [15:0] rand_seed();
        logic [15:0] s;
        s = 16'($urandom);
        if ($urandom_range(0, 3) == 0) s[7:0] = 8'h00;
        if ($urandom_range(0, 3) == 0) s[15:8] = 8'h00;
        return s;
    endfunction

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        exp_cap  = '0;
        reset    = 1'b1;
        restart  = 1'b0;
        mode     = '0;
        seed     = '0;
        out_port = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_values("por");
        reset = 1'b0;

        run_check(4'b1110, 16'h00FE, -1, 1'b1, 16'hA55A, 1'b1);
        check("cap A55A", cap_data, 16'hA55A);

        for (int i = 0; i < 6; i++) begin
            do_restart();
            if (i == 2) begin
                run_check(4'($urandom), rand_seed(), RSTC + 10, 1'b0, 16'h0, 1'b0);
                run_check(4'($urandom), rand_seed(), -1, 1'b0, 16'h0, 1'b0);
            end else begin
                run_check(4'($urandom), rand_seed(), -1, 1'b0, 16'h0, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
